// File: rtl/pixel_transform_sequencer.sv
// Issue-side sequencer for the pixel-transform datapath: raster-scans output coordinates
// over a valid/ready handshake, bounds in-flight work with a credit count, pulses done at frame end.
module pixel_transform_sequencer #(
  parameter int WIDTH        = 640,
  parameter int HEIGHT       = 480,
  parameter int XW           = 10,
  parameter int YW           = 9,
  parameter int MAX_INFLIGHT = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  output logic          coord_valid,
  input  logic          coord_ready,
  output logic [XW-1:0] x_out,
  output logic [YW-1:0] y_out,
  input  logic          result_valid,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    state_dbg
);

  // Handshake: a coordinate transfers on any rising edge where coord_valid and
  // coord_ready are both high; x_out/y_out hold steady until that transfer.
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [7:0]    MAX_CNT = 8'(MAX_INFLIGHT);
  localparam logic [XW-1:0] X_LAST  = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(HEIGHT - 1);

  state_t        state;
  state_t        state_next;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [7:0]    inflight;
  logic [7:0]    inflight_next;
  logic          accept;
  logic          last_accept;
  logic          underflow;

  assign coord_valid = (state == ISSUE) && (inflight != MAX_CNT);
  assign accept      = coord_valid && coord_ready;
  assign last_accept = accept && (x == X_LAST) && (y == Y_LAST);
  assign x_out       = x;
  assign y_out       = y;
  assign done        = (state == DONE);
  assign state_dbg   = state;

  // Accept and result in the same cycle cancel; a result with nothing outstanding is an underflow.
  always_comb begin
    inflight_next = inflight;
    underflow     = 1'b0;
    if (accept && !result_valid) begin
      inflight_next = inflight + 8'd1;
    end else if (!accept && result_valid) begin
      if (inflight == 8'd0) underflow = 1'b1;
      else                  inflight_next = inflight - 8'd1;
    end
  end

  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_next = ISSUE;
        ISSUE:   if (last_accept) state_next = DRAIN;
        DRAIN:   if (inflight_next == 8'd0) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      x        <= '0;
      y        <= '0;
      inflight <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == ISSUE) || (state_next == DRAIN);
      if (abort) begin
        x        <= '0;
        y        <= '0;
        inflight <= '0;
      end else if ((state == IDLE) && start) begin
        x        <= '0;
        y        <= '0;
        inflight <= '0;
        err      <= 1'b0;
      end else begin
        inflight <= inflight_next;
        if (underflow) err <= 1'b1;
        // The final coordinate stays on x/y once issued.
        if (accept && !last_accept) begin
          if (x == X_LAST) begin
            x <= '0;
            y <= y + YW'(1);
          end else begin
            x <= x + XW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_transform_sequencer.sv
// Bench for pixel_transform_sequencer: a small datapath emulator, a raster-list reference model
// compared against the DUT every cycle, and directed scenarios with literal expectations.
module tb_pixel_transform_sequencer;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int M  = 4;
  localparam int XW = 2;
  localparam int YW = 2;
  localparam int CW = XW + YW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          coord_ready = 1'b0;
  logic          result_valid = 1'b0;
  logic          coord_valid;
  logic [XW-1:0] x_out;
  logic [YW-1:0] y_out;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    state_dbg;

  pixel_transform_sequencer #(
    .WIDTH(W), .HEIGHT(H), .XW(XW), .YW(YW), .MAX_INFLIGHT(M)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .coord_valid(coord_valid), .coord_ready(coord_ready),
    .x_out(x_out), .y_out(y_out), .result_valid(result_valid),
    .busy(busy), .done(done), .err(err), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode 0: idle, 1: frame running, 2: completion cycle.
  // exp_q holds the coordinates ({y,x}) of the frame still to be handed out.
  int            m_mode = 0;
  int            m_out  = 0;
  bit            m_err  = 1'b0;
  logic [CW-1:0] exp_q[$];

  function automatic bit m_cv();
    return (m_mode == 1) && (exp_q.size() != 0) && (m_out < M);
  endfunction

  always @(posedge clk) begin
    bit acc;
    acc = m_cv() && coord_ready;
    if (reset) begin
      m_mode = 0; m_out = 0; m_err = 1'b0; exp_q.delete();
    end else if (abort) begin
      m_mode = 0; m_out = 0; exp_q.delete();
    end else if (m_mode == 0) begin
      if (start) begin
        m_mode = 1; m_out = 0; m_err = 1'b0;
        for (int yy = 0; yy < H; yy++)
          for (int xx = 0; xx < W; xx++)
            exp_q.push_back({YW'(yy), XW'(xx)});
      end else if (result_valid) begin
        m_err = 1'b1;
      end
    end else if (m_mode == 2) begin
      if (result_valid) m_err = 1'b1;
      m_mode = 0;
    end else begin
      if (acc) void'(exp_q.pop_front());
      if (acc && !result_valid) m_out++;
      else if (result_valid && !acc) begin
        if (m_out == 0) m_err = 1'b1;
        else m_out--;
      end
      if (exp_q.size() == 0 && m_out == 0) m_mode = 2;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [CW-1:0] head;
    if (!reset) begin
      check("coord_valid", coord_valid, m_cv());
      check("busy", busy, m_mode == 1);
      check("done", done, m_mode == 2);
      check("err", err, m_err);
      if (m_cv()) begin
        head = exp_q[0];
        check("x_out", x_out, head[XW-1:0]);
        check("y_out", y_out, head[CW-1:XW]);
      end
    end
  end

  // ---------------- datapath emulator (sole driver of coord_ready/result_valid) ----------------
  int            cyc = 0;
  int            ret_q[$];
  bit            hold = 1'b0;
  bit            kick = 1'b0;
  int            lat_min = 3;
  int            lat_max = 3;
  int            ready_mode = 0;
  int            rdy_ph = 0;
  logic [CW-1:0] acc_log[$];

  always @(posedge clk) begin
    if (reset || abort) ret_q.delete();
    else if (coord_valid && coord_ready) begin
      ret_q.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
      acc_log.push_back({y_out, x_out});
    end
    cyc++;
    #1;
    result_valid = 1'b0;
    if (kick) begin
      result_valid = 1'b1;
      if (ret_q.size() > 0) void'(ret_q.pop_front());
      kick = 1'b0;
    end else if (!hold && ret_q.size() > 0 && ret_q[0] <= cyc) begin
      result_valid = 1'b1;
      void'(ret_q.pop_front());
    end
    case (ready_mode)
      0:       coord_ready = 1'b1;
      1:       begin coord_ready = (rdy_ph % 3 == 0); rdy_ph++; end
      default: coord_ready = 1'($urandom_range(1, 0));
    endcase
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_frame();
    tick(); start = 1'b1;
    tick(); start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound);
    bit seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    check(name, seen, 1);
  endtask

  task automatic check_raster(input string name);
    check({name, "_accepts"}, acc_log.size(), W * H);
    for (int i = 0; i < W * H && i < acc_log.size(); i++)
      check({name, "_order"}, acc_log[i], i);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scenarios ----------------
  initial begin
    int cnt;
    int busy_cnt;
    bit fin;
    bit do_abort;
    int abort_at;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_coord_valid", coord_valid, 0);
    check("reset_x", x_out, 0);
    check("reset_y", y_out, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    repeat (2) tick();

    // Nominal frame, fixed 3-cycle return latency.
    ready_mode = 0; lat_min = 3; lat_max = 3; acc_log.delete();
    start_frame();
    cnt = 1;
    busy_cnt = busy ? 1 : 0;
    while (!done && cnt < 60) begin
      tick();
      cnt++;
      if (busy) busy_cnt++;
    end
    check("nominal_start_to_done", cnt, 16);
    check("nominal_busy_cycles", busy_cnt, 15);
    check("nominal_err", err, 0);
    check_raster("nominal");
    tick();
    check("nominal_done_single", done, 0);
    repeat (3) tick();

    // Backpressure pattern 1,0,0 with varying latency.
    ready_mode = 1; rdy_ph = 0; lat_min = 1; lat_max = 4; acc_log.delete();
    start_frame();
    wait_done("backpressure_done", 300);
    check_raster("backpressure");
    repeat (3) tick();

    // Credit limit: results withheld, then one released.
    ready_mode = 0; hold = 1'b1; lat_min = 1; lat_max = 1; acc_log.delete();
    start_frame();
    check("credit_first_valid", coord_valid, 1);
    check("credit_first_x", x_out, 0);
    check("credit_first_y", y_out, 0);
    repeat (20) tick();
    check("credit_accepts", acc_log.size(), 4);
    check("credit_stalled", coord_valid, 0);
    @(negedge clk) kick = 1'b1;
    @(posedge clk);
    @(posedge clk); #2;
    check("credit_reassert", coord_valid, 1);
    check("credit_reassert_x", x_out, 0);
    check("credit_reassert_y", y_out, 1);
    hold = 1'b0;
    wait_done("credit_done", 200);
    check_raster("credit");
    repeat (3) tick();

    // Start while busy is ignored.
    ready_mode = 2; lat_min = 1; lat_max = 6; acc_log.delete();
    start_frame();
    repeat (5) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("restart_ignored_done", 300);
    check_raster("restart_ignored");
    repeat (3) tick();

    // Abort at the 6th accept.
    ready_mode = 0; lat_min = 3; lat_max = 3; acc_log.delete();
    start_frame();
    for (int i = 0; i < 50 && acc_log.size() < 5; i++) tick();
    check("abort_reached_5", acc_log.size(), 5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_coord_valid", coord_valid, 0);
    check("abort_done", done, 0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) cnt++;
    end
    check("abort_no_done", cnt, 0);
    acc_log.delete();
    start_frame();
    check("abort_restart_x", x_out, 0);
    check("abort_restart_y", y_out, 0);
    check("abort_restart_valid", coord_valid, 1);
    wait_done("abort_restart_done", 200);
    check_raster("abort_restart");
    repeat (3) tick();

    // Underflow in IDLE sets err until the next start.
    @(negedge clk) kick = 1'b1;
    @(posedge clk);
    @(posedge clk); #2;
    check("underflow_err_set", err, 1);
    repeat (5) tick();
    check("underflow_err_sticky", err, 1);
    acc_log.delete();
    start_frame();
    check("underflow_err_cleared", err, 0);
    wait_done("underflow_frame_done", 200);
    check("underflow_frame_err", err, 0);
    repeat (3) tick();

    // Randomized frames with stray starts and occasional aborts.
    for (int f = 0; f < 8; f++) begin
      ready_mode = 2; lat_min = 1; lat_max = 8;
      do_abort = ($urandom_range(3, 0) == 0);
      abort_at = $urandom_range(30, 5);
      start_frame();
      fin = 1'b0;
      for (int c = 0; c < 400 && !fin; c++) begin
        tick();
        start = ($urandom_range(15, 0) == 0);
        if (do_abort && c == abort_at) begin
          abort = 1'b1;
          fin = 1'b1;
        end else if (done) begin
          fin = 1'b1;
        end
      end
      tick();
      start = 1'b0;
      abort = 1'b0;
      check("rand_frame_end", fin, 1);
      repeat (3) tick();
    end

    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
